// File: rtl/rocketcpu_wb_pkg.sv
// Shared definitions for the RocketFPGA Wishbone initiator: state encoding,
// audio register map bases and default timing parameters.
package rocketcpu_wb_pkg;

    // Two-state bus sequencer: waiting for a command, or a cycle in flight.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } wb_state_t;

    // Audio register responders on the SoC bus.
    localparam logic [31:0] AUDIO_PARAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] AUDIO_STATUS_BASE = 32'h1001_0000;

    // Cycles a slave gets to ack before the initiator gives up.
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Cycles cyc stays low between cycles; two swallow the late ack the
    // audio responders emit after a cycle ends.
    localparam int DEFAULT_IDLE_GAP = 2;

    // Width of the timeout counter.
    localparam int DEFAULT_TW = 16;

    // True when an address falls inside one of the 64 KiB audio windows.
    function automatic logic is_audio_reg(input logic [31:0] adr);
        return (adr[31:16] == AUDIO_PARAM_BASE[31:16]) ||
               (adr[31:16] == AUDIO_STATUS_BASE[31:16]);
    endfunction

endpackage

// File: rtl/rocketcpu_wb_initiator.sv
// Wishbone classic initiator: turns single-beat read/write commands from a
// valid/ready port into Wishbone cycles and hands back read data together
// with an ack/timeout status. The legal range of TIMEOUT_CYCLES is 4..65535,
// IDLE_GAP must be at least 2, and TW must hold TIMEOUT_CYCLES.
module rocketcpu_wb_initiator
    import rocketcpu_wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int IDLE_GAP       = DEFAULT_IDLE_GAP,
    parameter int TW             = DEFAULT_TW
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,

    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [31:0] i_cmd_adr,
    input  logic [31:0] i_cmd_dat,
    input  logic [3:0]  i_cmd_sel,
    input  logic        i_cmd_we,

    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_dat,
    output logic        o_rsp_err,

    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    // The gap counter only has to reach IDLE_GAP.
    localparam int            GW       = (IDLE_GAP < 2) ? 2 : $clog2(IDLE_GAP + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_GAP);

    wb_state_t     state_q;
    wb_state_t     state_d;
    logic [TW-1:0] to_cnt_q;
    logic [GW-1:0] gap_cnt_q;

    logic accept;
    logic ack_hit;
    logic timeout_hit;
    logic bus_done;
    logic rsp_retire;

    // Strobe is never deasserted inside a cycle, so it simply mirrors cyc.
    assign o_wb_stb = o_wb_cyc;

    // State register.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on an accepted command, return when the cycle
    // ends through either an ack or the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_BUS;
            ST_BUS:  if (bus_done) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // Handshake and cycle-termination decodes, all from registered state
    // except the ack itself; ack beats the timeout when both land together.
    always_comb begin
        o_cmd_ready = (state_q == ST_IDLE) && (gap_cnt_q == '0) && !o_rsp_valid;
        accept      = i_cmd_valid && o_cmd_ready;
        ack_hit     = (state_q == ST_BUS) && i_wb_ack;
        timeout_hit = (state_q == ST_BUS) && !i_wb_ack && (to_cnt_q == TO_LAST);
        bus_done    = ack_hit || timeout_hit;
        rsp_retire  = o_rsp_valid && i_rsp_ready;
    end

    // Bus request registers: address, data and selects latch on accept and
    // hold while idle, so cyc alone says whether the bus is in use.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            o_wb_adr <= '0;
            o_wb_dat <= '0;
            o_wb_sel <= '0;
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
        end else if (accept) begin
            o_wb_adr <= i_cmd_adr;
            o_wb_dat <= i_cmd_dat;
            o_wb_sel <= i_cmd_sel;
            o_wb_we  <= i_cmd_we;
            o_wb_cyc <= 1'b1;
        end else if (bus_done) begin
            o_wb_we  <= 1'b0;
            o_wb_cyc <= 1'b0;
        end
    end

    // Timeout counter: counts cycles spent waiting for ack in BUS.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if ((state_q == ST_BUS) && !bus_done) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Gap counter: reloads when a cycle ends and drains while idle, keeping
    // the bus quiet long enough for a lagging slave ack to go away. Reset
    // loads it too, so an ack left over from an interrupted cycle is absorbed.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            gap_cnt_q <= GAP_LOAD;
        end else if (bus_done) begin
            gap_cnt_q <= GAP_LOAD;
        end else if ((state_q == ST_IDLE) && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
        end
    end

    // Response slot: filled when the cycle ends, held stable until the
    // consumer takes it. Writes and timeouts return zero data.
    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst_n) begin
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b0;
        end else if (ack_hit) begin
            o_rsp_valid <= 1'b1;
            o_rsp_dat   <= o_wb_we ? 32'h0 : i_wb_rdt;
            o_rsp_err   <= 1'b0;
        end else if (timeout_hit) begin
            o_rsp_valid <= 1'b1;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b1;
        end else if (rsp_retire) begin
            o_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rocketcpu_wb_initiator.sv
// Testbench for rocketcpu_wb_initiator, with a behavioural audio register
// responder as the Wishbone slave (ack two cycles after cyc, stale ack after).
module tb_rocketcpu_wb_initiator;
    import rocketcpu_wb_pkg::*;

    localparam int TO  = 8;
    localparam int GAP = 2;

    typedef struct {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        cmd_we = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_rdt;
    logic        wb_ack;

    logic        force_ack = 1'b0;
    logic [31:0] force_rdt = '0;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;
    int cyc_run = 0;
    int low_run = 0;
    int last_cyc_len = 0;
    int last_low_len = 0;
    int cyc_count = 0;
    int stb_mismatch = 0;
    bit rsp_valid_seen = 0;
    exp_t exp_q[$];

    rocketcpu_wb_initiator #(
        .TIMEOUT_CYCLES(TO),
        .IDLE_GAP(GAP),
        .TW(16)
    ) dut (
        .i_wb_clk(clk),
        .i_wb_rst_n(rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_adr(cmd_adr),
        .i_cmd_dat(cmd_dat),
        .i_cmd_sel(cmd_sel),
        .i_cmd_we(cmd_we),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_dat(rsp_dat),
        .o_rsp_err(rsp_err),
        .o_wb_adr(wb_adr),
        .o_wb_dat(wb_dat),
        .o_wb_sel(wb_sel),
        .o_wb_we(wb_we),
        .o_wb_cyc(wb_cyc),
        .o_wb_stb(wb_stb),
        .i_wb_rdt(wb_rdt),
        .i_wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    // Audio register responder: eight parameter words plus a status window.
    // Ack follows cyc by two cycles and lingers after the cycle ends; it is
    // not reset, so an interrupted cycle still produces a late ack.
    logic [31:0] mem [8] = '{32'hA000_0000, 32'hA000_0101, 32'hA000_0202, 32'hA000_0303,
                             32'hA000_0404, 32'hA000_0505, 32'hA000_0606, 32'hA000_0707};
    logic [1:0]  ack_pipe = 2'b00;
    logic        mapped_q = 1'b0;
    logic        slave_ack;
    logic [31:0] slave_rdt;

    assign slave_ack = ack_pipe[1] && mapped_q;
    assign slave_rdt = (wb_adr[31:16] == AUDIO_PARAM_BASE[31:16]) ? mem[wb_adr[4:2]] :
                       (32'h5A7A_0000 | {16'h0, wb_adr[15:0]});
    assign wb_ack = slave_ack || force_ack;
    assign wb_rdt = force_ack ? force_rdt : slave_rdt;

    // Slave pipeline and register writes.
    always @(posedge clk) begin
        ack_pipe <= {ack_pipe[0], wb_cyc};
        if (wb_cyc) mapped_q <= is_audio_reg(wb_adr);
        if (slave_ack && wb_cyc && wb_we && wb_adr[31:16] == AUDIO_PARAM_BASE[31:16]) begin
            for (int b = 0; b < 4; b++)
                if (wb_sel[b]) mem[wb_adr[4:2]][8*b +: 8] <= wb_dat[8*b +: 8];
        end
    end

    // Model of the slave's reset contents.
    function automatic logic [31:0] init_word(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0101;
    endfunction

    // Bus and response monitor, sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (wb_stb !== wb_cyc) stb_mismatch++;
            if (wb_cyc === 1'b1) begin
                if (cyc_run == 0) last_low_len = low_run;
                cyc_run++;
                low_run = 0;
            end else begin
                if (cyc_run != 0) begin
                    last_cyc_len = cyc_run;
                    cyc_count++;
                end
                cyc_run = 0;
                low_run++;
            end
            if (rsp_valid === 1'b1) rsp_valid_seen = 1;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                rsp_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rsp_unexpected: got dat=%08h err=%0b, required no response", rsp_dat, rsp_err);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rsp_dat !== e.dat || rsp_err !== e.err) begin
                        failures++;
                        $display("[TB] FAIL rsp_data: got dat=%08h err=%0b, required dat=%08h err=%0b",
                                 rsp_dat, rsp_err, e.dat, e.err);
                    end
                end
            end
        end
    end

    // Offers a command and returns at #1 after the accepting edge.
    task automatic issue_cmd(input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic we);
        bit rdy;
        bit done;
        done = 0;
        cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_we = we; cmd_valid = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            rdy = cmd_ready;
            @(posedge clk); #1;
            if (rdy) done = 1;
        end
        cmd_valid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL cmd_accept: adr=%08h got not accepted, required accepted within 300 cycles", adr);
        end
    endtask

    // Waits for the bus, the response slot and the scoreboard to drain.
    task automatic wait_idle(input string tag);
        bit done;
        done = 0;
        for (int n = 0; n < 300 && !done; n++) begin
            if (!wb_cyc && !rsp_valid && exp_q.size() == 0 && cmd_ready) done = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL %s_idle: got busy (pending=%0d), required idle within 300 cycles", tag, exp_q.size());
        end
    endtask

    task automatic push_exp(input logic [31:0] dat, input logic err);
        exp_t e;
        e.dat = dat;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Counts cycles from reset release until the initiator is ready.
    task automatic check_ready_after_reset(input string tag);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != GAP) begin
            failures++;
            $display("[TB] FAIL %s_ready_delay: got %0d cycles, required %0d", tag, n, GAP);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0) begin failures++; $display("[TB] FAIL reset_cyc: got cyc=%b stb=%b, required 0 0", wb_cyc, wb_stb); end
        if (wb_we !== 1'b0 || wb_sel !== 4'h0) begin failures++; $display("[TB] FAIL reset_we_sel: got we=%b sel=%h, required 0 0", wb_we, wb_sel); end
        if (wb_adr !== 32'h0 || wb_dat !== 32'h0) begin failures++; $display("[TB] FAIL reset_adr_dat: got adr=%08h dat=%08h, required 0 0", wb_adr, wb_dat); end
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b, required 0", rsp_valid); end
        if (rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp: got dat=%08h err=%b, required 0 0", rsp_dat, rsp_err); end
        if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_cmd_ready: got %b, required 0", cmd_ready); end
        rst_n = 1'b1;
        check_ready_after_reset("reset");
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        push_exp(32'h0, 1'b0);
        issue_cmd(AUDIO_PARAM_BASE + 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b1);
        wait_idle("write");
        checks++;
        if (last_cyc_len != 3) begin failures++; $display("[TB] FAIL write_cyc_len: got %0d, required 3", last_cyc_len); end
        push_exp(32'hDEAD_BEEF, 1'b0);
        issue_cmd(AUDIO_PARAM_BASE + 32'h4, 32'h0, 4'hF, 1'b0);
        wait_idle("read");
        checks += 2;
        if (last_cyc_len != 3) begin failures++; $display("[TB] FAIL read_cyc_len: got %0d, required 3", last_cyc_len); end
        if (wb_adr !== AUDIO_PARAM_BASE + 32'h4) begin failures++; $display("[TB] FAIL adr_hold: got %08h, required %08h", wb_adr, AUDIO_PARAM_BASE + 32'h4); end
    endtask

    task automatic test_back_to_back();
        int c0;
        int r0;
        c0 = cyc_count;
        r0 = rsp_seen;
        rsp_ready = 1'b1;
        push_exp(init_word(0), 1'b0);
        issue_cmd(AUDIO_PARAM_BASE, 32'h0, 4'hF, 1'b0);
        push_exp(init_word(2), 1'b0);
        issue_cmd(AUDIO_PARAM_BASE + 32'h8, 32'h0, 4'hF, 1'b0);
        wait_idle("b2b");
        checks += 3;
        if (cyc_count - c0 != 2) begin failures++; $display("[TB] FAIL b2b_cycles: got %0d, required 2", cyc_count - c0); end
        if (rsp_seen - r0 != 2) begin failures++; $display("[TB] FAIL b2b_responses: got %0d, required 2", rsp_seen - r0); end
        if (last_low_len < GAP) begin failures++; $display("[TB] FAIL b2b_gap: got %0d low cycles, required >= %0d", last_low_len, GAP); end
    endtask

    task automatic test_timeout();
        rsp_ready = 1'b1;
        push_exp(32'h0, 1'b1);
        issue_cmd(32'h2000_0000, 32'h0, 4'hF, 1'b0);
        wait_idle("timeout");
        checks++;
        if (last_cyc_len != TO) begin failures++; $display("[TB] FAIL timeout_cyc_len: got %0d, required %0d", last_cyc_len, TO); end
    endtask

    task automatic test_backpressure();
        logic [31:0] held_dat;
        bit stable;
        bit done;
        rsp_ready = 1'b0;
        push_exp(init_word(3), 1'b0);
        issue_cmd(AUDIO_PARAM_BASE + 32'hC, 32'h0, 4'hF, 1'b0);
        done = 0;
        for (int n = 0; n < 50 && !done; n++) begin
            if (rsp_valid) done = 1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!done) begin failures++; $display("[TB] FAIL bp_rsp_arrive: got no response, required response within 50 cycles"); end
        held_dat = rsp_dat;
        stable = 1;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || cmd_ready !== 1'b0) stable = 0;
        end
        checks += 2;
        if (!stable) begin failures++; $display("[TB] FAIL bp_hold: got valid/dat/ready changing, required held with cmd_ready=0"); end
        if (held_dat !== init_word(3)) begin failures++; $display("[TB] FAIL bp_dat: got %08h, required %08h", held_dat, init_word(3)); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_retire: got rsp_valid=%b, required 0", rsp_valid); end
        if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_ready_after: got cmd_ready=%b, required 1", cmd_ready); end
        push_exp(init_word(5), 1'b0);
        issue_cmd(AUDIO_PARAM_BASE + 32'h14, 32'h0, 4'hF, 1'b0);
        wait_idle("bp_next");
    endtask

    task automatic test_reset_mid_bus();
        int r0;
        r0 = rsp_seen;
        rsp_ready = 1'b1;
        issue_cmd(AUDIO_PARAM_BASE, 32'h0, 4'hF, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (wb_cyc !== 1'b0) begin failures++; $display("[TB] FAIL rst_bus_cyc: got %b, required 0", wb_cyc); end
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_bus_rsp_valid: got %b, required 0", rsp_valid); end
        rsp_valid_seen = 0;
        rst_n = 1'b1;
        check_ready_after_reset("rst_bus");
        repeat (6) @(posedge clk);
        #1;
        checks += 2;
        if (rsp_valid_seen) begin failures++; $display("[TB] FAIL rst_bus_late_ack: got rsp_valid=1, required no response"); end
        if (rsp_seen != r0) begin failures++; $display("[TB] FAIL rst_bus_rsp_count: got %0d, required 0", rsp_seen - r0); end
    endtask

    task automatic test_ack_at_timeout();
        rsp_ready = 1'b1;
        push_exp(32'hF00D_CAFE, 1'b0);
        issue_cmd(32'h2000_0000, 32'h0, 4'hF, 1'b0);
        repeat (TO - 1) begin @(posedge clk); #1; end
        force_rdt = 32'hF00D_CAFE;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        wait_idle("ack_to");
        checks++;
        if (last_cyc_len != TO) begin failures++; $display("[TB] FAIL ack_to_cyc_len: got %0d, required %0d", last_cyc_len, TO); end
    endtask

    initial begin
        $display("[TB] starting rocketcpu_wb_initiator bench");
        test_reset();
        test_write_read();
        test_back_to_back();
        test_timeout();
        test_backpressure();
        test_reset_mid_bus();
        test_ack_at_timeout();
        repeat (3) @(posedge clk);
        #1;
        checks += 2;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size()); end
        if (stb_mismatch != 0) begin failures++; $display("[TB] FAIL stb_eq_cyc: got %0d mismatching cycles, required 0", stb_mismatch); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
